// File: rtl/run_arbiter.sv
// ============================================================================
// Module   : run_arbiter
// Merges two run_finder streams into one valid/ready token stream, with a
// line/frame barrier. Optional build macro: RUN_ARB_RR_EN (round-robin grant).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_arbiter #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] ch0_run_start,
  input  logic [W-1:0] ch0_run_end,
  input  logic         ch0_new_run,
  input  logic         ch0_end_line,
  input  logic         ch0_end_frame,
  input  logic [W-1:0] ch1_run_start,
  input  logic [W-1:0] ch1_run_end,
  input  logic         ch1_new_run,
  input  logic         ch1_end_line,
  input  logic         ch1_end_frame,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_chan,
  output logic         out_has_run,
  output logic [W-1:0] out_start,
  output logic [W-1:0] out_end,
  output logic         out_eol,
  output logic         out_eof,
  output logic [1:0]   ovf,
  output logic         desync
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 2*W + 3;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SYNC0 = 2'd1,
    ST_SYNC1 = 2'd2
  } state_t;

  // Token layout: {start, end, has_run, eol, eof}
  logic [TW-1:0] in_tok [2];
  logic [TW-1:0] head   [2];
  logic [1:0]    wr;
  logic [1:0]    pop;
  logic [1:0]    full;
  logic [1:0]    nonempty;
  logic [1:0]    ovf_ev;

  assign in_tok[0] = {ch0_run_start, ch0_run_end, ch0_new_run, ch0_end_line, ch0_end_frame};
  assign in_tok[1] = {ch1_run_start, ch1_run_end, ch1_new_run, ch1_end_line, ch1_end_frame};
  assign wr[0]     = ch0_new_run | ch0_end_line | ch0_end_frame;
  assign wr[1]     = ch1_new_run | ch1_end_line | ch1_end_frame;

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          accept;

    assign full[k]     = (cnt == (AW+1)'(DEPTH));
    assign nonempty[k] = (cnt != '0);
    // A simultaneous pop frees the slot, so a full FIFO still takes the write.
    assign accept      = wr[k] & (~full[k] | pop[k]);
    assign ovf_ev[k]   = wr[k] & full[k] & ~pop[k];
    assign head[k]     = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (accept) wptr <= wptr + AW'(1);
        if (pop[k]) rptr <= rptr + AW'(1);
        cnt <= cnt + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop[k]};
      end
    end

    always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= in_tok[k];
    end
  end

  logic [1:0] h_eof;
  logic [1:0] h_eol;
  logic [1:0] h_run;
  logic [1:0] elig;

  assign h_eof = {head[1][0], head[0][0]};
  assign h_eol = {head[1][1], head[0][1]};
  assign h_run = {head[1][2], head[0][2]};
  assign elig  = nonempty & ~(h_eol | h_eof);

  state_t        state;
  state_t        state_nx;
  logic          locked;
  logic          lock_chan;
  logic          sav_eol;
  logic          sav_eof;
  logic          gnt;
  logic          valid;
  logic          chan;
  logic          eol_o;
  logic          eof_o;
  logic          desync_set;
  logic          eof_xfer;
  logic [TW-1:0] sel_tok;

`ifdef RUN_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == ST_ARB && valid && out_ready) begin
      rr_ptr <= ~gnt;
    end
  end

  always_comb begin
    gnt = 1'b0;
    if (locked)             gnt = lock_chan;
    else if (elig == 2'b11) gnt = rr_ptr;
    else                    gnt = ~elig[0];
  end
`else
  always_comb begin
    gnt = 1'b0;
    if (locked) gnt = lock_chan;
    else        gnt = ~elig[0];
  end
`endif

  always_comb begin
    state_nx   = state;
    pop        = 2'b00;
    valid      = 1'b0;
    chan       = 1'b0;
    eol_o      = 1'b0;
    eof_o      = 1'b0;
    desync_set = 1'b0;
    case (state)
      ST_ARB: begin
        if (elig != 2'b00) begin
          valid    = 1'b1;
          chan     = gnt;
          pop[gnt] = out_ready;
        end else if (nonempty == 2'b11) begin
          state_nx   = ST_SYNC0;
          desync_set = h_eof[0] ^ h_eof[1];
        end
      end
      ST_SYNC0: begin
        if (h_run[0]) begin
          valid = 1'b1;
          if (out_ready) begin
            pop[0]   = 1'b1;
            state_nx = ST_SYNC1;
          end
        end else begin
          // Bare marker on channel 0: consume it silently.
          pop[0]   = 1'b1;
          state_nx = ST_SYNC1;
        end
      end
      ST_SYNC1: begin
        valid = 1'b1;
        chan  = 1'b1;
        eol_o = sav_eol | h_eol[1];
        eof_o = sav_eof | h_eof[1];
        if (out_ready) begin
          pop[1]   = 1'b1;
          state_nx = ST_ARB;
        end
      end
      default: state_nx = ST_ARB;
    endcase
  end

  assign sel_tok     = head[chan];
  assign out_valid   = valid;
  assign out_chan    = valid & chan;
  assign out_has_run = valid & sel_tok[2];
  assign out_start   = valid ? sel_tok[TW-1 -: W] : '0;
  assign out_end     = valid ? sel_tok[W+2 -: W]  : '0;
  assign out_eol     = valid & eol_o;
  assign out_eof     = valid & eof_o;
  assign eof_xfer    = valid & out_ready & eof_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      locked    <= 1'b0;
      lock_chan <= 1'b0;
      sav_eol   <= 1'b0;
      sav_eof   <= 1'b0;
      ovf       <= 2'b00;
      desync    <= 1'b0;
    end else begin
      state     <= state_nx;
      locked    <= valid & ~out_ready;
      lock_chan <= chan;
      if (state == ST_SYNC0) begin
        sav_eol <= h_eol[0];
        sav_eof <= h_eof[0];
      end
      // A new event in the clearing cycle still sets the flag.
      ovf    <= (eof_xfer ? 2'b00 : ovf) | ovf_ev;
      desync <= (eof_xfer ? 1'b0 : desync) | desync_set;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_run_arbiter.sv
// ============================================================================
// Module   : tb_run_arbiter
// Self-checking scoreboard bench for run_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_arbiter;

  localparam int W     = 11;
  localparam int DEPTH = 8;
  localparam int TW    = 2*W + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] ch0_run_start, ch0_run_end, ch1_run_start, ch1_run_end;
  logic         ch0_new_run, ch0_end_line, ch0_end_frame;
  logic         ch1_new_run, ch1_end_line, ch1_end_frame;
  logic         out_ready;
  logic         out_valid, out_chan, out_has_run, out_eol, out_eof, desync;
  logic [W-1:0] out_start, out_end;
  logic [1:0]   ovf;

  int n_total  = 0;
  int n_bad    = 0;
  int eol_seen = 0;
  logic [TW-1:0] sb [$];
  logic [TW-1:0] exp_tok;

  always #5 clk = ~clk;

  run_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_run_start(ch0_run_start), .ch0_run_end(ch0_run_end),
    .ch0_new_run(ch0_new_run), .ch0_end_line(ch0_end_line), .ch0_end_frame(ch0_end_frame),
    .ch1_run_start(ch1_run_start), .ch1_run_end(ch1_run_end),
    .ch1_new_run(ch1_new_run), .ch1_end_line(ch1_end_line), .ch1_end_frame(ch1_end_frame),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_has_run(out_has_run), .out_start(out_start), .out_end(out_end),
    .out_eol(out_eol), .out_eof(out_eof), .ovf(ovf), .desync(desync)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] tk(input logic c, input logic r, input int s, input int e,
                                       input logic l, input logic f);
    return {c, r, W'(s), W'(e), l, f};
  endfunction

  // Every transfer is checked against the head of the expected-token queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (out_eol) eol_seen++;
      if (sb.size() == 0) begin
        check_val("extra token", 64'(sb.size()), 64'(1));
      end else begin
        exp_tok = sb.pop_front();
        check_val("token", {out_chan, out_has_run, out_start, out_end, out_eol, out_eof}, exp_tok);
      end
    end
  end

  task automatic clear_in();
    ch0_run_start = '0; ch0_run_end = '0; ch0_new_run = 0; ch0_end_line = 0; ch0_end_frame = 0;
    ch1_run_start = '0; ch1_run_end = '0; ch1_new_run = 0; ch1_end_line = 0; ch1_end_frame = 0;
  endtask

  task automatic put0(input logic r, input int s, input int e, input logic l, input logic f);
    ch0_new_run = r; ch0_run_start = W'(s); ch0_run_end = W'(e);
    ch0_end_line = l; ch0_end_frame = f;
  endtask

  task automatic put1(input logic r, input int s, input int e, input logic l, input logic f);
    ch1_new_run = r; ch1_run_start = W'(s); ch1_run_end = W'(e);
    ch1_end_line = l; ch1_end_frame = f;
  endtask

  task automatic commit();
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || out_valid) && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    check_val("drain pending", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    idle(2);
    check_val("rst valid", out_valid, 0);
    check_val("rst start", out_start, 0);
    check_val("rst eol",   out_eol, 0);
    check_val("rst ovf",   ovf, 0);
    check_val("rst desync", desync, 0);
    rst_n = 1'b1;
    idle(1);

    // Single run, one-cycle latency
    out_ready = 1'b1;
    put0(1, 5, 9, 0, 0);
    sb.push_back(tk(0, 1, 5, 9, 0, 0));
    commit();
    check_val("t1 valid", out_valid, 1);
    check_val("t1 chan",  out_chan, 0);
    check_val("t1 start", out_start, 5);
    check_val("t1 end",   out_end, 9);
    check_val("t1 eol",   out_eol, 0);
    drain();

    // Line barrier: one merged eol
    eol_seen = 0;
    put0(1, 1, 3, 1, 0);
    put1(0, 0, 0, 1, 0);
    sb.push_back(tk(0, 1, 1, 3, 0, 0));
    sb.push_back(tk(1, 0, 0, 0, 1, 0));
    commit();
    drain();
    check_val("t2 eol count", eol_seen, 1);

    // Backpressure: ch1 becomes eligible but cannot preempt ch0
    out_ready = 1'b0;
    put0(1, 20, 30, 0, 0);
    sb.push_back(tk(0, 1, 20, 30, 0, 0));
    commit();
    put1(1, 40, 50, 0, 0);
    sb.push_back(tk(1, 1, 40, 50, 0, 0));
    commit();
    repeat (4) begin
      check_val("t3 valid", out_valid, 1);
      check_val("t3 chan",  out_chan, 0);
      check_val("t3 start", out_start, 20);
      check_val("t3 end",   out_end, 30);
      idle(1);
    end
    out_ready = 1'b1;
    drain();

    // Arbitration order with three preloaded runs per channel
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put0(1, 100 + i, 110 + i, 0, 0);
      put1(1, 200 + i, 210 + i, 0, 0);
      commit();
    end
`ifdef RUN_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      sb.push_back(tk(0, 1, 100 + i, 110 + i, 0, 0));
      sb.push_back(tk(1, 1, 200 + i, 210 + i, 0, 0));
    end
`else
    for (int i = 0; i < 3; i++) sb.push_back(tk(0, 1, 100 + i, 110 + i, 0, 0));
    for (int i = 0; i < 3; i++) sb.push_back(tk(1, 1, 200 + i, 210 + i, 0, 0));
`endif
    out_ready = 1'b1;
    drain();

    // Overflow: ninth run into a full ch0 FIFO is lost
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put0(1, 300 + i, 400 + i, 0, 0);
      if (i < DEPTH) sb.push_back(tk(0, 1, 300 + i, 400 + i, 0, 0));
      commit();
    end
    check_val("t5 ovf set", ovf, 2'b01);
    out_ready = 1'b1;
    drain();
    check_val("t5 ovf sticky", ovf, 2'b01);
    put0(0, 0, 0, 0, 1);
    put1(0, 0, 0, 0, 1);
    sb.push_back(tk(1, 0, 0, 0, 0, 1));
    commit();
    drain();
    check_val("t5 ovf clear", ovf, 2'b00);
    check_val("t5 desync", desync, 0);

    // Desync: ch0 eof against ch1 eol
    out_ready = 1'b0;
    put0(0, 0, 0, 0, 1);
    put1(0, 0, 0, 1, 0);
    sb.push_back(tk(1, 0, 0, 0, 1, 1));
    commit();
    check_val("t6 desync early", desync, 0);
    idle(2);
    check_val("t6 desync set", desync, 1);
    check_val("t6 valid", out_valid, 1);
    check_val("t6 chan",  out_chan, 1);
    check_val("t6 eol",   out_eol, 1);
    check_val("t6 eof",   out_eof, 1);
    out_ready = 1'b1;
    drain();
    check_val("t6 desync clear", desync, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    put0(1, 7, 8, 0, 0);
    put1(1, 9, 10, 0, 0);
    commit();
    put0(1, 11, 12, 0, 0);
    commit();
    check_val("t7 valid before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t7 valid async", out_valid, 0);
    check_val("t7 start async", out_start, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check_val("t7 empty after", out_valid, 0);
    check_val("t7 ovf", ovf, 0);

    check_val("sb empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
